// File: rtl/grover_pkg.sv
// Shared widths, LFSR constants and FSM encoding for the grover measurement stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package grover_pkg;

  localparam int unsigned AMP_W    = 8;            // Q1.6 signed amplitude
  localparam int unsigned N_STATES = 8;            // basis states
  localparam int unsigned IDX_W    = 3;            // basis-state index width
  localparam int unsigned SQ_W     = 2 * AMP_W;    // squared amplitude
  localparam int unsigned SUM_W    = 2 * AMP_W + 3; // sum of N_STATES squares

  localparam int unsigned         LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]   LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQUARE = 3'd1,
    ST_DRAW   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/grover_lfsr.sv
// 16-bit Galois LFSR (taps 0xB400) that free-runs every cycle outside reset.
// Latency: value updates on every rising edge; lfsr shows the current register.
// Backpressure: none; never stalls.
// Ports: clk, rst (async active-high, loads SEED), lfsr (current state).
module grover_lfsr
  import grover_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr
);

  // The all-zero state is a lock-up state for this LFSR, so a zero seed
  // is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/grover_measure.sv
// Measurement stage: squares 8 amplitudes and draws one basis-state index weighted by amp^2.
// Latency: meas_valid rises on the 18th rising edge after the amp_valid/amp_ready edge.
// Backpressure: result held stable in OUT until meas_ready; amp_ready low whenever not IDLE.
// Ports: clk, rst (async active-high); amp_valid/amp_ready + amp0..amp7 in;
//        meas_valid/meas_ready + meas_index, meas_prob, zero_err out.
// Build option: GROVER_MEASURE_ARGMAX_EN selects the largest-weight index
//               (lowest index on ties) instead of a random draw.
module grover_measure
  import grover_pkg::*;
#(
  parameter int unsigned       AMP_W = grover_pkg::AMP_W,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    amp_valid,
  output logic                    amp_ready,
  input  logic signed [AMP_W-1:0] amp0,
  input  logic signed [AMP_W-1:0] amp1,
  input  logic signed [AMP_W-1:0] amp2,
  input  logic signed [AMP_W-1:0] amp3,
  input  logic signed [AMP_W-1:0] amp4,
  input  logic signed [AMP_W-1:0] amp5,
  input  logic signed [AMP_W-1:0] amp6,
  input  logic signed [AMP_W-1:0] amp7,
  output logic                    meas_valid,
  input  logic                    meas_ready,
  output logic [IDX_W-1:0]        meas_index,
  output logic [2*AMP_W-1:0]      meas_prob,
  output logic                    zero_err
);

  localparam int unsigned SQW  = 2 * AMP_W;
  localparam int unsigned SUMW = 2 * AMP_W + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STATES - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [AMP_W-1:0] amp_q [N_STATES];
  logic signed [AMP_W-1:0] amp_d [N_STATES];
  logic [SQW-1:0]          sq_q  [N_STATES];
  logic [SQW-1:0]          sq_d  [N_STATES];
  logic [SUMW-1:0]         total_q, total_d;
  logic [IDX_W-1:0]        sel_q, sel_d;

  logic                    meas_valid_q, meas_valid_d;
  logic [IDX_W-1:0]        meas_index_q, meas_index_d;
  logic [SQW-1:0]          meas_prob_q, meas_prob_d;
  logic                    zero_err_q, zero_err_d;

  logic [LFSR_W-1:0]       lfsr;
  logic signed [SQW-1:0]   amp_ext;
  logic signed [SQW-1:0]   prod_s;
  logic [SQW-1:0]          sq_now;
  logic [SQW-1:0]          sq_cur;
  logic                    total_zero;

`ifdef GROVER_MEASURE_ARGMAX_EN
  logic [SQW-1:0]          best_q, best_d;
  logic                    unused_lfsr;
  assign unused_lfsr = ^lfsr;
`else
  logic [SUMW-1:0]         thr_q, thr_d;
  logic [SUMW-1:0]         cum_q, cum_d;
  logic                    found_q, found_d;
  logic [LFSR_W+SUMW-1:0]  draw_prod;
  logic [SUMW-1:0]         cum_next;
`endif

  grover_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Sign-extend before multiplying so the square of -2^(AMP_W-1) still fits.
  assign amp_ext    = SQW'(amp_q[cnt_q]);
  assign prod_s     = amp_ext * amp_ext;
  assign sq_now     = prod_s;
  assign sq_cur     = sq_q[cnt_q];
  assign total_zero = (total_q == '0);

`ifndef GROVER_MEASURE_ARGMAX_EN
  // Scaling a uniform 16-bit value by total gives 0 <= thr < total.
  assign draw_prod = {{SUMW{1'b0}}, lfsr} * {{LFSR_W{1'b0}}, total_q};
  assign cum_next  = cum_q + SUMW'(sq_cur);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    amp_d        = amp_q;
    sq_d         = sq_q;
    total_d      = total_q;
    sel_d        = sel_q;
    meas_valid_d = meas_valid_q;
    meas_index_d = meas_index_q;
    meas_prob_d  = meas_prob_q;
    zero_err_d   = zero_err_q;
`ifdef GROVER_MEASURE_ARGMAX_EN
    best_d       = best_q;
`else
    thr_d        = thr_q;
    cum_d        = cum_q;
    found_d      = found_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (amp_valid) begin
          amp_d[0] = amp0;
          amp_d[1] = amp1;
          amp_d[2] = amp2;
          amp_d[3] = amp3;
          amp_d[4] = amp4;
          amp_d[5] = amp5;
          amp_d[6] = amp6;
          amp_d[7] = amp7;
          total_d  = '0;
          sel_d    = '0;
          cnt_d    = '0;
          state_d  = ST_SQUARE;
        end
      end

      ST_SQUARE: begin
        sq_d[cnt_q] = sq_now;
        total_d     = total_q + SUMW'(sq_now);
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
`ifndef GROVER_MEASURE_ARGMAX_EN
        thr_d   = draw_prod[LFSR_W +: SUMW];
        cum_d   = '0;
        found_d = 1'b0;
`endif
        state_d = ST_SCAN;
      end

      ST_SCAN: begin
`ifdef GROVER_MEASURE_ARGMAX_EN
        // Strict compare keeps the earliest index on ties.
        if ((cnt_q == '0) || (sq_cur > best_q)) begin
          best_d = sq_cur;
          sel_d  = cnt_q;
        end
`else
        cum_d = cum_next;
        if (!found_q && (cum_next > thr_q)) begin
          found_d = 1'b1;
          sel_d   = cnt_q;
        end
`endif
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        // First OUT cycle commits the result to the output registers;
        // the handshake is only possible once meas_valid is up.
        if (!meas_valid_q) begin
          meas_valid_d = 1'b1;
          zero_err_d   = total_zero;
          meas_index_d = total_zero ? '0 : sel_q;
          meas_prob_d  = total_zero ? '0 : sq_q[sel_q];
        end else if (meas_ready) begin
          meas_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      amp_q        <= '{default: '0};
      sq_q         <= '{default: '0};
      total_q      <= '0;
      sel_q        <= '0;
      meas_valid_q <= 1'b0;
      meas_index_q <= '0;
      meas_prob_q  <= '0;
      zero_err_q   <= 1'b0;
`ifdef GROVER_MEASURE_ARGMAX_EN
      best_q       <= '0;
`else
      thr_q        <= '0;
      cum_q        <= '0;
      found_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      amp_q        <= amp_d;
      sq_q         <= sq_d;
      total_q      <= total_d;
      sel_q        <= sel_d;
      meas_valid_q <= meas_valid_d;
      meas_index_q <= meas_index_d;
      meas_prob_q  <= meas_prob_d;
      zero_err_q   <= zero_err_d;
`ifdef GROVER_MEASURE_ARGMAX_EN
      best_q       <= best_d;
`else
      thr_q        <= thr_d;
      cum_q        <= cum_d;
      found_q      <= found_d;
`endif
    end
  end

  assign amp_ready  = (state_q == ST_IDLE);
  assign meas_valid = meas_valid_q;
  assign meas_index = meas_index_q;
  assign meas_prob  = meas_prob_q;
  assign zero_err   = zero_err_q;

endmodule

// File: tb/tb_grover_measure.sv
// Self-checking bench for grover_measure: directed cases, randomized traffic, distribution run.
// Latency: expects meas_valid 18 edges after acceptance.
// Backpressure: exercises meas_ready stalls and amp_valid while busy.
module tb_grover_measure;

  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst;
  logic              amp_valid;
  logic              amp_ready;
  logic signed [7:0] amp [8];
  logic              meas_valid;
  logic              meas_ready;
  logic [2:0]        meas_index;
  logic [15:0]       meas_prob;
  logic              zero_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  grover_measure #(
    .AMP_W (8),
    .SEED  (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .amp_valid  (amp_valid),
    .amp_ready  (amp_ready),
    .amp0       (amp[0]),
    .amp1       (amp[1]),
    .amp2       (amp[2]),
    .amp3       (amp[3]),
    .amp4       (amp[4]),
    .amp5       (amp[5]),
    .amp6       (amp[6]),
    .amp7       (amp[7]),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_index (meas_index),
    .meas_prob  (meas_prob),
    .zero_err   (zero_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level helpers: one LFSR step, and the draw outcome for the current amp inputs.
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [19:0] model_draw(input logic [15:0] lf);
    longint sq [8];
    longint total, thr, cum;
    int     idx;
    bit     found;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      sq[i] = longint'(amp[i]) * longint'(amp[i]);
      total += sq[i];
    end
    if (total == 0) return {1'b1, 3'd0, 16'd0};
    idx = 0;
`ifdef GROVER_MEASURE_ARGMAX_EN
    thr = longint'(lf) * 0;
    for (int i = 1; i < 8; i++) if (sq[i] > sq[idx] + thr) idx = i;
`else
    thr   = (longint'(lf) * total) >> 16;
    cum   = 0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cum += sq[i];
      if (!found && cum > thr) begin
        idx   = i;
        found = 1'b1;
      end
    end
`endif
    return {1'b0, 3'(idx), 16'(sq[idx])};
  endfunction

  // Transaction-level model: idle / busy counting edges / presenting a result.
  bit          m_idle  = 1'b1;
  bit          m_valid = 1'b0;
  int          m_k     = 0;
  logic [2:0]  m_idx   = '0;
  logic [15:0] m_prob  = '0;
  logic        m_zerr  = 1'b0;
  logic [15:0] m_lfsr  = SEED;
  logic [19:0] m_pend  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_k     <= 0;
      m_idx   <= '0;
      m_prob  <= '0;
      m_zerr  <= 1'b0;
      m_lfsr  <= SEED;
    end else begin
      logic [15:0] lf;
      m_lfsr <= lstep(m_lfsr);
      if (m_idle) begin
        if (amp_valid) begin
          // The draw uses the LFSR value present one cycle after 8 squaring cycles.
          lf = m_lfsr;
          for (int s = 0; s < 9; s++) lf = lstep(lf);
          m_pend <= model_draw(lf);
          m_idle <= 1'b0;
          m_k    <= 1;
        end
      end else if (!m_valid) begin
        if (m_k == 18) begin
          m_valid <= 1'b1;
          m_zerr  <= m_pend[19];
          m_idx   <= m_pend[18:16];
          m_prob  <= m_pend[15:0];
        end else begin
          m_k <= m_k + 1;
        end
      end else if (meas_ready) begin
        m_valid <= 1'b0;
        m_idle  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_amp_ready", amp_ready, m_idle);
      chk("cyc_meas_valid", meas_valid, m_valid);
      chk("cyc_meas_index", meas_index, m_idx);
      chk("cyc_meas_prob", meas_prob, m_prob);
      chk("cyc_zero_err", zero_err, m_zerr);
    end
  end

  task automatic set_amps(input int a0, a1, a2, a3, a4, a5, a6, a7);
    amp[0] = 8'(a0); amp[1] = 8'(a1); amp[2] = 8'(a2); amp[3] = 8'(a3);
    amp[4] = 8'(a4); amp[5] = 8'(a5); amp[6] = 8'(a6); amp[7] = 8'(a7);
  endtask

  // Pulse amp_valid from IDLE and return edges until meas_valid (bounded).
  task automatic launch(output int lat);
    amp_valid = 1'b1;
    @(posedge clk); #1;
    amp_valid = 1'b0;
    lat = 0;
    while (!meas_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_directed(input string name, input int e_idx, input int e_prob, input int e_z);
    int lat;
    launch(lat);
    chk({name, "_latency"}, lat, 18);
    chk({name, "_index"}, meas_index, e_idx);
    chk({name, "_prob"}, meas_prob, e_prob);
    chk({name, "_zero_err"}, zero_err, e_z);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] r;
    int lat, vcnt, draws, c3, cyc;
    rst = 1'b1; amp_valid = 1'b0; meas_ready = 1'b1;
    set_amps(0, 0, 0, 0, 0, 0, 0, 0);

    // Hand-computed pins on the model itself.
    chk("pin_lstep", lstep(16'hACE1), 16'hE270);
    set_amps(0, 0, 0, 0, 0, 64, 0, 0);
    r = model_draw(16'h1234);
    chk("pin_peak", r, {1'b0, 3'd5, 16'd4096});
    set_amps(8, 8, 8, 60, 8, 8, 8, 8);
`ifdef GROVER_MEASURE_ARGMAX_EN
    r = model_draw(16'h0000);
    chk("pin_argmax", r, {1'b0, 3'd3, 16'd3600});
`else
    r = model_draw(16'h0000);
    chk("pin_thr_lo", r, {1'b0, 3'd0, 16'd64});
    r = model_draw(16'hFFFF);
    chk("pin_thr_hi", r, {1'b0, 3'd7, 16'd64});
`endif

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;
    chk("rst_amp_ready", amp_ready, 1);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_meas_index", meas_index, 0);
    chk("rst_meas_prob", meas_prob, 0);
    chk("rst_zero_err", zero_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_amps(0, 0, 0, 0, 0, 64, 0, 0);
    run_directed("peak5", 5, 4096, 0);
    set_amps(0, 0, -64, 0, 0, 0, 0, 0);
    run_directed("neg2", 2, 4096, 0);
    set_amps(0, 0, 0, 0, 0, 0, 0, 0);
    run_directed("zero", 0, 0, 1);

    // Backpressure with an ignored amp_valid while busy.
    set_amps(0, 0, 0, 0, 0, 0, -32, 0);
    meas_ready = 1'b0;
    launch(lat);
    chk("bp_latency", lat, 18);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        set_amps(0, 64, 0, 0, 0, 0, 0, 0);
        amp_valid = 1'b1;
      end
      if (k == 2) amp_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_hold_valid", meas_valid, 1);
      chk("bp_hold_amp_ready", amp_ready, 0);
      chk("bp_hold_index", meas_index, 6);
      chk("bp_hold_prob", meas_prob, 1024);
    end
    meas_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_amp_ready", amp_ready, 1);
    chk("bp_release_valid", meas_valid, 0);
    chk("bp_release_index_kept", meas_index, 6);

    // Reset in the middle of SCAN.
    amp_valid = 1'b1;
    @(posedge clk); #1;
    amp_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_amp_ready", amp_ready, 1);
    chk("midrst_meas_valid", meas_valid, 0);
    chk("midrst_meas_index", meas_index, 0);
    chk("midrst_meas_prob", meas_prob, 0);
    chk("midrst_zero_err", zero_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (meas_valid) vcnt++;
    end
    chk("midrst_no_result", vcnt, 0);

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      int mode, pk;
      @(posedge clk); #1;
      amp_valid  = ($urandom % 4) != 0;
      meas_ready = ($urandom % 3) != 0;
      rst        = ($urandom % 500) == 0;
      mode = $urandom % 8;
      pk   = $urandom % 8;
      for (int i = 0; i < 8; i++) begin
        if (mode == 0)      amp[i] = 8'sd0;
        else if (mode == 1) amp[i] = (i == pk) ? 8'($urandom) : 8'sd0;
        else                amp[i] = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; amp_valid = 1'b0; meas_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    // Back-to-back draws on a dominant amplitude.
    set_amps(8, 8, 8, 60, 8, 8, 8, 8);
    amp_valid = 1'b1;
    draws = 0; c3 = 0; cyc = 0;
    while (draws < 1000 && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      if (meas_valid) begin
        draws++;
        if (meas_index == 3'd3) c3++;
      end
    end
    amp_valid = 1'b0;
    chk("dist_draws", draws, 1000);
    $display("distribution: index 3 drawn %0d of %0d", c3, draws);
`ifdef GROVER_MEASURE_ARGMAX_EN
    chk("dist_idx3_all", c3, 1000);
`else
    chk("dist_idx3_in_range", (c3 >= 850 && c3 <= 930), 1);
`endif
    repeat (30) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grover_measure.md
Name: grover_measure

Overview:
- Measurement stage directly downstream of the grover amplitude engine.
- Accepts the 8 final state amplitudes when the engine signals done.
- Squares each amplitude into a probability weight and draws one basis-state index by weighted random sampling, using an internal LFSR.
- Returns the drawn index and its weight to the consumer through a valid/ready handshake.

Parameters:
- AMP_W, 8: amplitude width; signed two's complement, Q1.6 (64 = 1.0).
- SEED, 16'hACE1: LFSR reset value; 0 is illegal and is forced to 16'h0001.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- amp_valid  in  1  amplitudes valid (driven from grover done)
- amp_ready  out  1  block idle; can accept amplitudes
- amp0..amp7  in  AMP_W each  signed amplitudes of basis states 0..7
- meas_valid  out  1  result valid
- meas_ready  in  1  consumer accepts result
- meas_index  out  3  drawn basis state
- meas_prob  out  2*AMP_W  unsigned square of the chosen amplitude
- zero_err  out  1  all amplitudes were zero

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE; LFSR loads SEED.
  - amp_ready=1; meas_valid=0, meas_index=0, meas_prob=0, zero_err=0.
- LFSR:
  - 16-bit Galois, taps 0xB400.
  - Advances every clock cycle unless in reset.
- States and transitions:
  - IDLE:
    - amp_ready=1.
    - On amp_valid, latch amp0..amp7 into internal registers, clear the accumulator, and go to SQUARE.
  - SQUARE, 8 cycles:
    - Cycle i computes sq[i] = amp[i]*amp[i] as a signed product; the result is unsigned, 2*AMP_W bits.
    - Store sq[i]; total += sq[i]. The total is 2*AMP_W+3 bits wide and never overflows.
  - DRAW, 1 cycle:
    - thr = (lfsr * total) >> 16, giving 0 <= thr < total when total > 0.
  - SCAN, always 8 cycles, so latency is fixed:
    - Add sq[i] into the cumulative sum cum.
    - Record the first i with cum > thr; later indices do not override it.
  - OUT:
    - meas_valid=1; outputs hold stable while meas_ready=0.
    - On meas_ready, go to IDLE next cycle with meas_valid=0.
    - meas_index, meas_prob and zero_err keep their last values until the next OUT.
- Latency: meas_valid rises on the 18th rising edge after the accepting edge.
- amp_ready is 0 in every state except IDLE; amp_valid outside IDLE is ignored.
- total==0: zero_err=1, meas_index=0, meas_prob=0. Otherwise zero_err=0.
- Reset mid-operation: the operation is aborted immediately and all reset values apply; no partial result is ever presented.
- amp_valid held high after the handshake: a new measurement is accepted on the first IDLE cycle. This supports back-to-back sampling.

Optional Feature:
- Macro: GROVER_MEASURE_ARGMAX_EN
- Defined:
  - Deterministic mode. SCAN selects the index with the largest sq[i]; ties go to the lowest index.
  - DRAW is a 1-cycle no-op; latency stays 18.
  - The LFSR is still instantiated but not used.
- Undefined: weighted random sampling as described in Behaviour.

Decomposition:
- Shared package grover_pkg holds:
  - AMP_W, N_STATES=8, IDX_W=3
  - SQ_W=2*AMP_W, SUM_W=2*AMP_W+3
  - LFSR_W=16, LFSR_TAPS=16'hB400
  - state encoding for IDLE/SQUARE/DRAW/SCAN/OUT
- One sub-module, grover_lfsr: parameterised SEED, outputs the current LFSR value, async reset.

Test Plan:
- Reset: assert rst -> amp_ready=1, meas_valid=0, meas_index=0, meas_prob=0, zero_err=0.
- Single peak: amp5=64, others 0, pulse amp_valid -> meas_valid exactly 18 edges later, meas_index=5, meas_prob=4096, zero_err=0; holds for any SEED.
- Negative sign: amp2=8'hC0 (-64), others 0 -> meas_index=2, meas_prob=4096.
- All zero amplitudes -> zero_err=1, meas_index=0, meas_prob=0, latency still 18.
- Backpressure and reset:
  - Hold meas_ready=0 for 5 cycles -> outputs stable, amp_ready=0, and a second amp_valid is ignored.
  - Then meas_ready=1 -> amp_ready=1 on the next cycle.
  - Assert rst during SCAN -> all outputs return to reset values at once.
- Distribution: amp3=60, others 8, 1000 back-to-back draws.
  - Index 3 frequency in [85%,93%] (expected 3600/4048).
  - With GROVER_MEASURE_ARGMAX_EN: index 3 on every draw.
